date_setter: RTL

User-facing date-entry controller that drives the overwrite port of the digital calendar. It captures the calendar's current date, lets the operator edit day, month and year with increment/decrement buttons, clamps the result to a legal calendar date, then issues a single registered `date_ow` pulse with the new `date_in`. It sits between the debounced button front-end and `digital_calendar`, and feeds the display mux while editing.

---
 rtl/date_setter.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/date_setter.sv
// date_setter: operator date-entry controller for the digital calendar.
// Captures the calendar's current date and lets the operator edit day, month
// and year with inc/dec buttons. Every edited value is clamped to a legal
// calendar date. The controller then commits the date through a single
// registered overwrite strobe.
module date_setter #(
    parameter int YEARRES     = 12,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [YEARRES+8:0] date_cur,
    input  logic               btn_mode,
    input  logic               btn_inc,
    input  logic               btn_dec,
    input  logic               btn_cancel,
    output logic [YEARRES+8:0] date_in,
    output logic               date_ow,
    output logic [YEARRES+8:0] edit_date,
    output logic               set_active,
    output logic [1:0]         field_sel
);

    localparam int DW    = YEARRES + 9;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        IDLE,
        EDIT_DAY,
        EDIT_MONTH,
        EDIT_YEAR,
        COMMIT
    } state_t;

    state_t state, state_nxt;

    logic [4:0]         day_q,  day_nxt;
    logic [3:0]         mon_q,  mon_nxt;
    logic [YEARRES-1:0] year_q, year_nxt;
    logic [CNT_W-1:0]   tmo_cnt, tmo_nxt;

    logic [DW-1:0] date_in_q;
    logic          date_ow_q;

    logic [4:0]         cur_day;
    logic [3:0]         cur_mon;
    logic [YEARRES-1:0] cur_year;

    logic any_btn;
    logic step_up;
    logic step_dn;
    logic step_any;

    assign cur_day  = date_cur[DW-1 -: 5];
    assign cur_mon  = date_cur[YEARRES +: 4];
    assign cur_year = date_cur[YEARRES-1:0];

    // inc and dec in the same cycle cancel each other out
    assign any_btn  = btn_mode | btn_inc | btn_dec | btn_cancel;
    assign step_up  = btn_inc & ~btn_dec;
    assign step_dn  = btn_dec & ~btn_inc;
    assign step_any = step_up | step_dn;

    // Days in a month; the leap rule (year[1:0]==0) matches the calendar's
    function automatic logic [4:0] month_len(input logic [3:0] m,
                                             input logic [YEARRES-1:0] y);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: month_len = 5'd30;
            4'd2:                    month_len = (y[1:0] == 2'd0) ? 5'd29 : 5'd28;
            default:                 month_len = 5'd31;
        endcase
    endfunction

    // Saturate a day to the month length (used after month/year changes)
    function automatic logic [4:0] clamp_day(input logic [4:0] d,
                                             input logic [4:0] len);
        clamp_day = (d > len) ? len : d;
    endfunction

    // Sanitise a captured month: out-of-range values become January
    function automatic logic [3:0] sanitise_mon(input logic [3:0] m);
        sanitise_mon = ((m == 4'd0) || (m > 4'd12)) ? 4'd1 : m;
    endfunction

    // Sanitise a captured day: zero becomes 1; too-large values saturate
    function automatic logic [4:0] sanitise_day(input logic [4:0] d,
                                                input logic [4:0] len);
        if (d == 5'd0)
            sanitise_day = 5'd1;
        else
            sanitise_day = clamp_day(d, len);
    endfunction

    // Day step with wrap: len -> 1 going up, 1 -> len going down
    function automatic logic [4:0] day_step(input logic [4:0] d,
                                            input logic [4:0] len,
                                            input logic       up);
        if (up)
            day_step = (d >= len) ? 5'd1 : d + 5'd1;
        else
            day_step = (d <= 5'd1) ? len : d - 5'd1;
    endfunction

    // Month step with wrap: 12 -> 1 going up, 1 -> 12 going down
    function automatic logic [3:0] mon_step(input logic [3:0] m,
                                            input logic       up);
        if (up)
            mon_step = (m >= 4'd12) ? 4'd1 : m + 4'd1;
        else
            mon_step = (m <= 4'd1) ? 4'd12 : m - 4'd1;
    endfunction

    // Year step: plain modulo-2^YEARRES wrap
    function automatic logic [YEARRES-1:0] year_step(input logic [YEARRES-1:0] y,
                                                     input logic               up);
        year_step = up ? y + YEARRES'(1) : y - YEARRES'(1);
    endfunction

    // Next-state, edit-register and timeout-counter logic
    always_comb begin
        state_nxt = state;
        day_nxt   = day_q;
        mon_nxt   = mon_q;
        year_nxt  = year_q;
        tmo_nxt   = tmo_cnt;

        case (state)
            IDLE: begin
                tmo_nxt = '0;
                if (btn_mode) begin
                    mon_nxt   = sanitise_mon(cur_mon);
                    year_nxt  = cur_year;
                    day_nxt   = sanitise_day(cur_day,
                                             month_len(sanitise_mon(cur_mon), cur_year));
                    state_nxt = EDIT_DAY;
                end else begin
                    // Shadow the calendar so the display shows live time
                    day_nxt  = cur_day;
                    mon_nxt  = cur_mon;
                    year_nxt = cur_year;
                end
            end

            EDIT_DAY, EDIT_MONTH, EDIT_YEAR: begin
                if (any_btn)
                    tmo_nxt = '0;
                else if (tmo_cnt != CNT_SAT)
                    tmo_nxt = tmo_cnt + CNT_W'(1);

                if (btn_cancel) begin
                    state_nxt = IDLE;
                end else if (btn_mode) begin
                    case (state)
                        EDIT_DAY:   state_nxt = EDIT_MONTH;
                        EDIT_MONTH: state_nxt = EDIT_YEAR;
                        default:    state_nxt = COMMIT;
                    endcase
                end else if (step_any) begin
                    case (state)
                        EDIT_DAY: begin
                            day_nxt = day_step(day_q, month_len(mon_q, year_q), step_up);
                        end
                        EDIT_MONTH: begin
                            mon_nxt = mon_step(mon_q, step_up);
                            day_nxt = clamp_day(day_q,
                                                month_len(mon_step(mon_q, step_up), year_q));
                        end
                        default: begin
                            year_nxt = year_step(year_q, step_up);
                            day_nxt  = clamp_day(day_q,
                                                 month_len(mon_q, year_step(year_q, step_up)));
                        end
                    endcase
                end else if (!any_btn && (tmo_cnt >= CNT_LAST)) begin
                    // Idle too long: abandon the edit exactly like a cancel
                    state_nxt = IDLE;
                    tmo_nxt   = '0;
                end
            end

            COMMIT: begin
                tmo_nxt   = '0;
                state_nxt = IDLE;
            end

            default: begin
                tmo_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State register and timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_nxt;
        end
    end

    // Working copy of the date being edited
    always_ff @(posedge clk) begin
        if (rst) begin
            day_q  <= 5'd1;
            mon_q  <= 4'd1;
            year_q <= '0;
        end else begin
            day_q  <= day_nxt;
            mon_q  <= mon_nxt;
            year_q <= year_nxt;
        end
    end

    // Commit: date_in and the overwrite strobe load on the same edge
    // Both come straight from flops because the calendar treats date_ow as an async set
    always_ff @(posedge clk) begin
        if (rst) begin
            date_in_q <= {5'd1, 4'd1, {YEARRES{1'b0}}};
            date_ow_q <= 1'b0;
        end else begin
            date_ow_q <= (state == COMMIT);
            if (state == COMMIT)
                date_in_q <= {day_q, mon_q, year_q};
        end
    end

    // Status outputs decoded from the state register
    always_comb begin
        set_active = 1'b0;
        field_sel  = 2'd0;
        case (state)
            EDIT_DAY: begin
                set_active = 1'b1;
                field_sel  = 2'd1;
            end
            EDIT_MONTH: begin
                set_active = 1'b1;
                field_sel  = 2'd2;
            end
            EDIT_YEAR: begin
                set_active = 1'b1;
                field_sel  = 2'd3;
            end
            default: begin
                set_active = 1'b0;
                field_sel  = 2'd0;
            end
        endcase
    end

    assign edit_date = {day_q, mon_q, year_q};
    assign date_in   = date_in_q;
    assign date_ow   = date_ow_q;

endmodule
